sparse_encoder: RTL and testbench
=================================

# sparse_encoder

Dense-to-sparse (COO) front end for the sparse CNN datapath. Accepts one dense frame of pixels in raster order, drops zero values, and packs the non-zero entries with their column/row coordinates into the wide buses the PE consumes (`feature_*` / `weight_*`). A single parameterisation covers both operands: one instance for the 7x7 feature map (groups of 4, 52 slots) and one for the 5x5 kernel (groups of 1, 28 slots).

## Interface
- `col_length`, 8, width of one coordinate field
- `word_length`, 8, width of one value field
- `double_word_length`, 16, width of `valid_num`
- `image_size`, 7, frame edge length DIM; frame holds DIM*DIM pixels
- `depth`, 52, number of entry slots on the output buses; must be ≥ DIM*DIM rounded up to a multiple of `group`
- `group`, 4, consumer fetch granularity in entries (4 for features, 1 for weights)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pix_valid`  in  1  pixel offered
- `pix_in`  in  word_length  pixel value, signed
- `pix_ready`  out  1  encoder can accept a pixel this cycle
- `out_valid`  out  1  one-cycle pulse: frame packed, buses valid
- `valid_num`  out  double_word_length  ceil(nnz/group)
- `value_bus`  out  depth*word_length  packed values; entry k at bits [(k+1)*word_length-1 -: word_length]
- `cols_bus`  out  depth*col_length  packed column indices, same slot layout
- `rows_bus`  out  depth*col_length  packed row indices, same slot layout

## Operation
- Pixel accepted when `pix_valid && pix_ready`.
- FSM states:
  - COLLECT, entered at reset: `pix_ready`=1. Each accepted pixel advances the column counter (0..DIM-1, wraps) and, on a column wrap, the row counter.
  - DONE, entered when pixel (DIM-1, DIM-1) is accepted: `pix_ready`=0 and `out_valid`=1 for exactly one cycle, then back to COLLECT with counters at 0.
- A pixel is zero only when all bits are 0. Negative values are non-zero.
- Each non-zero pixel is written to slot `nnz` as (value, col, row), and `nnz` increments. Zero pixels only advance the coordinates.
- On acceptance of pixel (0,0) of every frame, all slots are cleared to 0 and `nnz` is cleared in the same cycle. Entry 0 is then written if that pixel is non-zero.
- Slots from `nnz` to `depth`-1 therefore read as value 0, col 0, row 0. This zero padding up to the next `group` boundary is what the consumer fetches.
- `valid_num` is registered on entry to DONE as (nnz+group-1)/group. It is zero-extended to `double_word_length`.
- Bus contents and `valid_num` hold from the `out_valid` cycle until the clock edge that accepts pixel (0,0) of the next frame.
- Any `pix_in` presented while `pix_ready`=0 is ignored; the source must hold it.

## Timing
- Reset (asynchronous, while `rst`=0):
  - FSM to COLLECT, counters and `nnz` to 0.
  - All bus slots, `valid_num` and `out_valid` to 0.
  - `pix_ready`=1.
- Write latency: a slot is visible on the bus the cycle after its pixel is accepted.
- Frame latency: the last pixel accepted at edge t gives `out_valid`=1 in cycle t+1 (registered, no combinational path from `pix_*`).
- Throughput: DIM*DIM+1 cycles per frame with `pix_valid` held high; one bubble (`pix_ready`=0) per frame.
- All-zero frame: `valid_num`=0, all slots 0, and `out_valid` still pulses.
- Fully dense frame: `nnz`=DIM*DIM with no overflow, guaranteed by the `depth` rule.
- Reset mid-frame: the partial frame is discarded, no `out_valid` is generated, and the next accepted pixel is (0,0).

## Test plan
- 7x7, group=4, pixels 5@(r0,c0), 0xFE@(r1,c3), 9@(r6,c6), all others 0 -> `out_valid` 1 cycle after the 49th pixel. Required: `valid_num`=1; slot0 (5,c0,r0); slot1 (0xFE,c3,r1); slot2 (9,c6,r6); slots 3..51 all 0.
- 7x7, group=4, all 49 pixels = 1 -> `valid_num`=13; slot k = (1, k%7, k/7) for k<49; slots 49..51 = 0.
- 7x7, all-zero frame -> `out_valid` pulses, `valid_num`=0, all buses 0.
- 5x5, group=1, depth=28, pixels 1..25 -> `valid_num`=25; slot 24 = (25,c4,r4); slots 25..27 = 0.
- Back-to-back frames with `pix_valid` held high:
  - Frame A has 10 non-zeros; frame B has 2 non-zeros.
  - Required: `pix_ready`=0 exactly one cycle per frame.
  - Required: frame B shows `valid_num`=1 with slots 2..51 cleared, i.e. no stale frame A entries.
- Assert `rst` low after 20 pixels, release, send a full frame -> no `out_valid` before the new frame's 49th pixel; results match the new frame only.

Source files
------------

// File: rtl/sparse_encoder.sv
// Dense-to-sparse (COO) encoder: drops zero pixels of one DIM x DIM raster frame and
// packs the non-zero (value, col, row) entries into wide slot buses for the PE.
module sparse_encoder #(
  parameter int col_length         = 8,
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 7,
  parameter int depth              = 52,
  parameter int group              = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_valid,
  input  logic [word_length-1:0]          pix_in,
  output logic                            pix_ready,
  output logic                            out_valid,
  output logic [double_word_length-1:0]   valid_num,
  output logic [depth*word_length-1:0]    value_bus,
  output logic [depth*col_length-1:0]     cols_bus,
  output logic [depth*col_length-1:0]     rows_bus
);

  localparam int NW = $clog2(depth + 1);
  localparam logic [col_length-1:0] LAST_COORD = col_length'(image_size - 1);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [col_length-1:0]   col_q, row_q;
  logic [NW-1:0]           nnz_q, nnz_d, wr_idx;
  logic                    accept, first_pix, last_pix, nonzero;
  logic [double_word_length-1:0] vn_calc;

  logic [word_length-1:0]  val_slot [depth];
  logic [col_length-1:0]   col_slot [depth];
  logic [col_length-1:0]   row_slot [depth];

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        pix_ready = 1'b1;
        if (pix_valid && last_pix) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign accept    = pix_valid && pix_ready;
  assign first_pix = (col_q == '0) && (row_q == '0);
  assign last_pix  = (col_q == LAST_COORD) && (row_q == LAST_COORD);
  assign nonzero   = |pix_in;

  // Pixel (0,0) restarts the packing at slot 0, so its write index ignores the old count.
  assign wr_idx  = first_pix ? '0 : nnz_q;
  assign nnz_d   = accept ? (wr_idx + NW'(nonzero)) : nnz_q;
  assign vn_calc = double_word_length'((32'(nnz_d) + 32'(group) - 32'd1) / 32'(group));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      col_q     <= '0;
      row_q     <= '0;
      nnz_q     <= '0;
      valid_num <= '0;
      for (int unsigned k = 0; k < depth; k++) begin
        val_slot[k] <= '0;
        col_slot[k] <= '0;
        row_slot[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      nnz_q   <= nnz_d;
      if (accept) begin
        if (col_q == LAST_COORD) begin
          col_q <= '0;
          row_q <= (row_q == LAST_COORD) ? '0 : row_q + col_length'(1);
        end else begin
          col_q <= col_q + col_length'(1);
        end
        // Clear and write share the edge; the later write wins for slot 0.
        for (int unsigned k = 0; k < depth; k++) begin
          if (first_pix) begin
            val_slot[k] <= '0;
            col_slot[k] <= '0;
            row_slot[k] <= '0;
          end
          if (nonzero && (NW'(k) == wr_idx)) begin
            val_slot[k] <= pix_in;
            col_slot[k] <= col_q;
            row_slot[k] <= row_q;
          end
        end
        if (last_pix) valid_num <= vn_calc;
      end
    end
  end

  always_comb begin
    value_bus = '0;
    cols_bus  = '0;
    rows_bus  = '0;
    for (int unsigned k = 0; k < depth; k++) begin
      value_bus[k*word_length +: word_length] = val_slot[k];
      cols_bus[k*col_length +: col_length]    = col_slot[k];
      rows_bus[k*col_length +: col_length]    = row_slot[k];
    end
  end

endmodule

// File: tb/tb_sparse_encoder.sv
// Self-checking bench for sparse_encoder: a 7x7/group-4 feature instance and a
// 5x5/group-1 weight instance, checked against a raster-scan COO reference model.
module tb_sparse_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic pv_f = 1'b0, pv_w = 1'b0;
  logic [7:0] pi_f = '0, pi_w = '0;
  logic rdy_f, ov_f, rdy_w, ov_w;
  logic [15:0] vn_f, vn_w;
  logic [415:0] val_f, col_f, row_f;
  logic [223:0] val_w, col_w, row_w;

  sparse_encoder #(.col_length(8), .word_length(8), .double_word_length(16),
                   .image_size(7), .depth(52), .group(4)) dut_f (
    .clk(clk), .rst(rst), .pix_valid(pv_f), .pix_in(pi_f), .pix_ready(rdy_f),
    .out_valid(ov_f), .valid_num(vn_f), .value_bus(val_f), .cols_bus(col_f), .rows_bus(row_f));

  sparse_encoder #(.col_length(8), .word_length(8), .double_word_length(16),
                   .image_size(5), .depth(28), .group(1)) dut_w (
    .clk(clk), .rst(rst), .pix_valid(pv_w), .pix_in(pi_w), .pix_ready(rdy_w),
    .out_valid(ov_w), .valid_num(vn_w), .value_bus(val_w), .cols_bus(col_w), .rows_bus(row_w));

  int unsigned checks = 0, passes = 0, fails = 0;
  logic [7:0]   frame [49];
  logic [415:0] exp_val, exp_col, exp_row;
  logic [15:0]  exp_vn;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the frame in raster order, append every non-zero pixel with its coordinates.
  task automatic model(input int dim, input int grp);
    int unsigned n;
    n = 0;
    exp_val = '0; exp_col = '0; exp_row = '0;
    for (int i = 0; i < dim * dim; i++) begin
      if (frame[i] != 8'h00) begin
        exp_val[n*8 +: 8] = frame[i];
        exp_col[n*8 +: 8] = 8'(i % dim);
        exp_row[n*8 +: 8] = 8'(i / dim);
        n++;
      end
    end
    exp_vn = 16'((n + grp - 1) / grp);
  endtask

  function automatic logic cur_rdy(input int sel);
    return (sel == 0) ? rdy_f : rdy_w;
  endfunction

  function automatic logic cur_ov(input int sel);
    return (sel == 0) ? ov_f : ov_w;
  endfunction

  function automatic logic [415:0] cur_bus(input int sel, input int which);
    logic [415:0] r;
    if (sel == 0) r = (which == 0) ? val_f : (which == 1) ? col_f : (which == 2) ? row_f : 416'(vn_f);
    else          r = (which == 0) ? 416'(val_w) : (which == 1) ? 416'(col_w) : (which == 2) ? 416'(row_w) : 416'(vn_w);
    return r;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    pv_f = (sel == 0) && v;
    pv_w = (sel == 1) && v;
    pi_f = d;
    pi_w = d;
  endtask

  task automatic check_outputs(input string tag, input int sel, input logic pulse);
    chk({tag, ".out_valid"}, 416'(cur_ov(sel)), 416'(pulse));
    chk({tag, ".valid_num"}, cur_bus(sel, 3), 416'(exp_vn));
    chk({tag, ".value_bus"}, cur_bus(sel, 0), exp_val);
    chk({tag, ".cols_bus"},  cur_bus(sel, 1), exp_col);
    chk({tag, ".rows_bus"},  cur_bus(sel, 2), exp_row);
  endtask

  task automatic run_frame(input string tag, input int sel, input int dim, input int grp,
                           input bit idle_after);
    int waits, early;
    waits = 0;
    early = 0;
    model(dim, grp);
    for (int i = 0; i < dim * dim; i++) begin
      @(negedge clk);
      drive(sel, 1'b1, frame[i]);
      if (cur_ov(sel)) early++;
      for (int n = 0; n < 20 && !cur_rdy(sel); n++) begin
        waits++;
        @(negedge clk);
        if (cur_ov(sel)) early++;
      end
    end
    @(negedge clk);
    chk({tag, ".stall_in_frame"}, 416'(waits), 416'(0));
    chk({tag, ".early_out_valid"}, 416'(early), 416'(0));
    chk({tag, ".bubble_ready"}, 416'(cur_rdy(sel)), 416'(0));
    check_outputs(tag, sel, 1'b1);
    if (idle_after) begin
      drive(sel, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk({tag, ".idle_ready"}, 416'(cur_rdy(sel)), 416'(1));
      check_outputs({tag, ".hold"}, sel, 1'b0);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 49; i++) frame[i] = 8'h00;
  endtask

  task automatic rand_frame(input int dim, input int pct);
    clear_frame();
    for (int i = 0; i < dim * dim; i++)
      if ($urandom_range(99) < pct) frame[i] = 8'($urandom_range(255, 1));
  endtask

  initial begin
    int cnt, p;
    clear_frame();

    #1 rst = 1'b0;
    #2;
    model(7, 4);
    check_outputs("reset_f", 0, 1'b0);
    chk("reset_f.ready", 416'(rdy_f), 416'(1));
    model(5, 1);
    check_outputs("reset_w", 1, 1'b0);
    chk("reset_w.ready", 416'(rdy_w), 416'(1));
    @(negedge clk);
    rst = 1'b1;

    clear_frame();
    frame[0] = 8'd5; frame[10] = 8'hFE; frame[48] = 8'd9;
    run_frame("sparse3", 0, 7, 4, 1'b1);

    for (int i = 0; i < 49; i++) frame[i] = 8'd1;
    run_frame("dense_ones", 0, 7, 4, 1'b1);

    clear_frame();
    run_frame("all_zero", 0, 7, 4, 1'b1);

    clear_frame();
    for (int i = 0; i < 25; i++) frame[i] = 8'(i + 1);
    run_frame("w_ramp", 1, 5, 1, 1'b1);

    clear_frame();
    cnt = 0;
    while (cnt < 10) begin
      p = int'($urandom_range(48));
      if (frame[p] == 8'h00) begin
        frame[p] = 8'($urandom_range(255, 1));
        cnt++;
      end
    end
    run_frame("b2b_A", 0, 7, 4, 1'b0);
    clear_frame();
    frame[3] = 8'd7; frame[40] = 8'h80;
    run_frame("b2b_B", 0, 7, 4, 1'b1);

    rand_frame(7, 60);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 1'b1, frame[i]);
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    clear_frame();
    model(7, 4);
    check_outputs("midreset", 0, 1'b0);
    chk("midreset.ready", 416'(rdy_f), 416'(1));
    @(negedge clk);
    rst = 1'b1;
    rand_frame(7, 50);
    run_frame("after_reset", 0, 7, 4, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rand_frame(7, int'($urandom_range(100)));
      run_frame("rand_f", 0, 7, 4, (r % 2) == 1);
    end
    for (int r = 0; r < 4; r++) begin
      rand_frame(5, int'($urandom_range(100)));
      run_frame("rand_w", 1, 5, 1, (r % 2) == 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
